// File: rtl/btn_event_scheduler_if.sv
// Bundle of the event-scheduler bus between the IO event sources / processor
// (master) and the scheduler (slave).
interface btn_event_scheduler_if #(
    parameter int N    = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 4
);
    // Handshake: EV_VALID rises when an event is presented and holds EV_ID/EV_CNT
    // stable until the master raises ACK; ACK is consumed only on a rising CLK
    // edge where EV_VALID=1, after which EV_VALID is low for at least one cycle.
    logic [N-1:0]    EV_IN;
    logic [N-1:0]    MASK;
    logic            ACK;
    logic            CLR_OVF;
    logic            EV_VALID;
    logic            IRQ;
    logic [IDW-1:0]  EV_ID;
    logic [CNTW-1:0] EV_CNT;
    logic [N-1:0]    OVF;

    modport master (
        output EV_IN, MASK, ACK, CLR_OVF,
        input  EV_VALID, IRQ, EV_ID, EV_CNT, OVF
    );

    modport slave (
        input  EV_IN, MASK, ACK, CLR_OVF,
        output EV_VALID, IRQ, EV_ID, EV_CNT, OVF
    );
endinterface

// File: rtl/btn_event_scheduler.sv
// Per-source saturating event counters with a round-robin presenter that hands
// one source's accumulated events at a time to the processor.
module btn_event_scheduler #(
    parameter int N    = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 4
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    btn_event_scheduler_if.slave   bus,
    output logic [0:0]             o_dbg_state
);
    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_PRESENT = 1'b1;
    localparam logic [CNTW-1:0] CNT_MAX   = '1;

    logic [0:0]      r_state;
    logic [CNTW-1:0] r_cnt [N];
    logic [IDW-1:0]  r_rr;
    logic [IDW-1:0]  r_win;
    logic [CNTW-1:0] r_snap;
    logic [N-1:0]    r_ovf;

    logic [CNTW-1:0] w_cnt_nxt [N];
    logic [CNTW-1:0] w_rem;
    logic [N-1:0]    w_ovf_set;
    logic [N-1:0]    w_elig;
    logic            w_ack_fire;
    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_rr_nxt;
    int              w_idx;

    assign w_ack_fire = (r_state == S_PRESENT) && bus.ACK;

    // Next counter values: consumption of the presented snapshot and any
    // same-cycle pulse are folded together so neither is lost.
    always_comb begin
        w_rem     = '0;
        w_ovf_set = '0;
        w_elig    = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_elig[i]    = (r_cnt[i] != '0) && !bus.MASK[i];
            if (w_ack_fire && (r_win == IDW'(i))) begin
                w_rem = r_cnt[i] - r_snap;
                if (bus.EV_IN[i] && (w_rem == CNT_MAX)) begin
                    w_ovf_set[i] = 1'b1;
                    w_cnt_nxt[i] = w_rem;
                end else begin
                    w_cnt_nxt[i] = w_rem + CNTW'(bus.EV_IN[i]);
                end
            end else if (bus.EV_IN[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_ovf_set[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search starting at r_rr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_rr) + k) % N;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDW'(w_idx);
            end
        end
    end

    assign w_rr_nxt = ((int'(r_win) + 1) == N) ? '0 : r_win + 1'b1;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_win   <= '0;
            r_snap  <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            // A new overflow in the same cycle as CLR_OVF keeps its bit set.
            r_ovf <= (bus.CLR_OVF ? '0 : r_ovf) | w_ovf_set;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_pick;
                        r_snap  <= w_cnt_nxt[w_pick];
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (bus.ACK) begin
                        r_rr    <= w_rr_nxt;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.EV_VALID = (r_state == S_PRESENT);
    assign bus.IRQ      = (r_state == S_PRESENT);
    assign bus.EV_ID    = r_win;
    assign bus.EV_CNT   = r_snap;
    assign bus.OVF      = r_ovf;
    assign o_dbg_state  = r_state;
endmodule
